// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between the LSU (port 0)
// and the debug loader (port 1); registered responses, error on illegal.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ADDR_MAX =
    DATA_WIDTH'(32'h0001FFFF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [DATA_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wd,
  input  logic [2:0]            req0_funct3,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rd,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [DATA_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wd,
  input  logic [2:0]            req1_funct3,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rd,
  output logic                  rsp1_err,
  output logic                  mem_WE,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wd;
    logic [2:0]            f3;
  } req_t;

  req_t r0, r1, sel;
  logic ptr;
  logic g0, g1, gnt;
  logic f3_ok, legal;
  logic [DATA_WIDTH-1:0] rd_nxt;

  assign r0 = {req0_we, req0_addr, req0_wd, req0_funct3};
  assign r1 = {req1_we, req1_addr, req1_wd, req1_funct3};

  // ptr=1 favours port 1 when both ports contend
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      g0 = req0_valid && (!req1_valid || !ptr);
      g1 = req1_valid && (!req0_valid || ptr);
    end
  end

  assign gnt = g0 | g1;
  assign sel = g1 ? r1 : r0;

  assign req0_ready = g0;
  assign req1_ready = g1;

  always_comb begin
    f3_ok = 1'b0;
    unique case (sel.f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !sel.we;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign legal  = f3_ok && (sel.addr <= ADDR_MAX);
  assign rd_nxt = (legal && !sel.we) ? mem_RD : '0;

  assign mem_WE     = gnt && sel.we && legal;
  assign mem_A      = sel.addr;
  assign mem_WD     = sel.wd;
  assign mem_funct3 = sel.f3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rd    <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rd    <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= g0;
      rsp1_valid <= g1;
      if (gnt) ptr <= g0;
      if (g0) begin
        rsp0_rd  <= rd_nxt;
        rsp0_err <= !legal;
      end
      if (g1) begin
        rsp1_rd  <= rd_nxt;
        rsp1_err <= !legal;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: byte-array memory plus a
// transaction-level reference model of grants and responses.
module tb_dmem_arbiter;

  localparam logic [31:0] AMAX = 32'h0001FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wd;
  logic [2:0]  req0_funct3;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rd;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wd;
  logic [2:0]  req1_funct3;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rd;
  logic        mem_WE;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wd(req0_wd), .req0_funct3(req0_funct3),
    .rsp0_valid(rsp0_valid), .rsp0_rd(rsp0_rd),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wd(req1_wd), .req1_funct3(req1_funct3),
    .rsp1_valid(rsp1_valid), .rsp1_rd(rsp1_rd),
    .rsp1_err(rsp1_err),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_funct3(mem_funct3), .mem_RD(mem_RD)
  );

  logic [7:0] emem [1024];
  logic [7:0] rmem [1024];
  logic [9:0] ei;

  function automatic logic [31:0] ext(
    input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // memory environment: combinational read, write at the edge
  assign ei = mem_A[9:0];
  always_comb
    mem_RD = ext({emem[ei+10'd3], emem[ei+10'd2],
                  emem[ei+10'd1], emem[ei]}, mem_funct3);

  always @(posedge clk) begin
    if (mem_WE) begin
      emem[ei] <= mem_WD[7:0];
      if (mem_funct3[1:0] != 2'b00)
        emem[ei+10'd1] <= mem_WD[15:8];
      if (mem_funct3[1]) begin
        emem[ei+10'd2] <= mem_WD[23:16];
        emem[ei+10'd3] <= mem_WD[31:24];
      end
    end
  end

  function automatic logic [31:0] rword(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {rmem[i+10'd3], rmem[i+10'd2],
            rmem[i+10'd1], rmem[i]};
  endfunction

  function automatic logic [31:0] eword(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {emem[i+10'd3], emem[i+10'd2],
            emem[i+10'd1], emem[i]};
  endfunction

  task automatic rstore(input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [2:0] f3);
    int n;
    logic [9:0] i;
    i = a[9:0];
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int k = 0; k < n; k++)
      rmem[i + 10'(k)] = wd[8*k +: 8];
  endtask

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model state
  bit          fav;
  bit          pv [2];
  logic [31:0] erd [2];
  bit          eerr [2];

  task automatic model_reset();
    fav = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pv[p]   = 1'b0;
      erd[p]  = '0;
      eerr[p] = 1'b0;
    end
  endtask

  task automatic chk_rsp();
    chk("rsp0_valid", 32'(rsp0_valid), 32'(pv[0]));
    chk("rsp0_rd", rsp0_rd, erd[0]);
    chk("rsp0_err", 32'(rsp0_err), 32'(eerr[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(pv[1]));
    chk("rsp1_rd", rsp1_rd, erd[1]);
    chk("rsp1_err", 32'(rsp1_err), 32'(eerr[1]));
  endtask

  task automatic drive_idle();
    req0_valid = 0; req0_we = 0; req0_addr = '0;
    req0_wd = '0; req0_funct3 = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0;
    req1_wd = '0; req1_funct3 = '0;
  endtask

  task automatic cycle(
    input bit v0, input bit we0, input logic [31:0] a0,
    input logic [31:0] wd0, input logic [2:0] f0,
    input bit v1, input bit we1, input logic [31:0] a1,
    input logic [31:0] wd1, input logic [2:0] f1);
    bit gv, we, lg;
    int g;
    logic [31:0] a, wd;
    logic [2:0] f;
    @(negedge clk);
    chk_rsp();
    req0_valid = v0; req0_we = we0; req0_addr = a0;
    req0_wd = wd0; req0_funct3 = f0;
    req1_valid = v1; req1_we = we1; req1_addr = a1;
    req1_wd = wd1; req1_funct3 = f1;
    #1;
    gv = v0 || v1;
    g  = (v0 && v1) ? int'(fav) : (v1 ? 1 : 0);
    chk("req0_ready", 32'(req0_ready), 32'(gv && g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(gv && g == 1));
    we = (g == 1) ? we1 : we0;
    a  = (g == 1) ? a1 : a0;
    wd = (g == 1) ? wd1 : wd0;
    f  = (g == 1) ? f1 : f0;
    lg = (a <= AMAX) &&
         (we ? (f inside {3'd0, 3'd1, 3'd2})
             : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
    chk("mem_WE", 32'(mem_WE), 32'(gv && we && lg));
    if (gv) begin
      chk("mem_A", mem_A, a);
      chk("mem_funct3", 32'(mem_funct3), 32'(f));
      if (we) chk("mem_WD", mem_WD, wd);
    end
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    if (gv) begin
      pv[g]   = 1'b1;
      erd[g]  = (lg && !we) ? ext(rword(a), f) : '0;
      eerr[g] = !lg;
      if (lg && we) rstore(a, wd, f);
      fav = (g == 0);
    end
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  function automatic logic [31:0] raddr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'h0002_0000 + 32'($urandom_range(0, 63));
    if (r == 1) return AMAX - 32'($urandom_range(0, 3));
    if (r == 2) return AMAX + 32'd1;
    if (r == 3) return 32'hFFFF_FFF0;
    return 32'($urandom_range(0, 63));
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      emem[i] = '0;
      rmem[i] = '0;
    end
    drive_idle();
    model_reset();
    req0_valid = 1; req0_we = 1; req0_funct3 = 3'd2;
    req1_valid = 1;
    repeat (2) @(negedge clk);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_we", 32'(mem_WE), 32'd0);
    drive_idle();
    rst = 1'b0;

    // contention from reset: strict alternation 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 32'h40 + 32'(4*k), '0, 3'd2,
            1, 0, 32'h80, '0, 3'd2);
      chk("rr_order", 32'(req1_ready), 32'(k % 2));
    end

    // sw then lw on port 0
    cycle(1, 1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 0, '0, '0, '0);
    cycle(1, 0, 32'h10, '0, 3'd2, 0, 0, '0, '0, '0);
    idle();
    chk("lw_back", rsp0_rd, 32'hDEADBEEF);

    // lb / lbu on port 1
    cycle(1, 1, 32'h10, 32'h80, 3'd2, 0, 0, '0, '0, '0);
    cycle(0, 0, '0, '0, '0, 1, 0, 32'h10, '0, 3'd0);
    idle();
    chk("lb_sext", rsp1_rd, 32'hFFFFFF80);
    cycle(0, 0, '0, '0, '0, 1, 0, 32'h10, '0, 3'd4);
    idle();
    chk("lbu_zext", rsp1_rd, 32'h00000080);

    // illegal store funct3 and out-of-range load
    cycle(1, 1, 32'h20, 32'hCAFE0001, 3'd2, 0, 0, '0, '0, '0);
    cycle(1, 1, 32'h20, 32'h1234, 3'd3, 0, 0, '0, '0, '0);
    chk("bad_st_we", 32'(mem_WE), 32'd0);
    idle();
    chk("bad_st_err", 32'(rsp0_err), 32'd1);
    cycle(1, 0, 32'h20, '0, 3'd2, 0, 0, '0, '0, '0);
    idle();
    chk("prior_val", rsp0_rd, 32'hCAFE0001);
    cycle(1, 0, 32'h0002_0000, '0, 3'd2, 0, 0, '0, '0, '0);
    idle();
    chk("oor_err", 32'(rsp0_err), 32'd1);

    // port 1 alone three times, then contention goes to port 0
    repeat (3) cycle(0, 0, '0, '0, '0, 1, 0, 32'h8, '0, 3'd2);
    cycle(1, 0, 32'h4, '0, 3'd2, 1, 0, 32'h8, '0, 3'd2);
    chk("p1_then_p0", 32'(req0_ready), 32'd1);

    // async reset in the middle of a granted store
    @(negedge clk);
    chk_rsp();
    drive_idle();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h30;
    req0_wd = 32'h55AA55AA; req0_funct3 = 3'd2;
    #1 chk("pre_rst_rdy", 32'(req0_ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdy0", 32'(req0_ready), 32'd0);
    chk("mid_rst_rdy1", 32'(req1_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_WE), 32'd0);
    @(negedge clk);
    model_reset();
    chk_rsp();
    chk("mem30_kept", eword(32'h30), 32'h0);
    drive_idle();
    rst = 1'b0;
    cycle(1, 0, 32'h30, '0, 3'd2, 1, 0, 32'h34, '0, 3'd2);
    chk("post_rst_p0", 32'(req0_ready), 32'd1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            raddr(), $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            raddr(), $urandom, 3'($urandom_range(0, 7)));
    end
    idle();
    idle();
    for (int i = 0; i < 64; i += 4)
      chk("mem_final", eword(32'(i)), rword(32'(i)));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter that shares the single-ported data memory between the CPU load/store unit (port 0) and the debug/program loader (port 1). It accepts at most one request per cycle over a valid/ready handshake and drives the memory's WE/A/WD/funct3 inputs. It returns registered read data one cycle after acceptance, and rejects illegal funct3 or out-of-range addresses with an error response instead of touching memory.

Parameters:
DATA_WIDTH, 32, width of address, write data and read data
ADDR_MAX, 32'h0001FFFF, highest legal memory index; any address above it is out of range

Ports:
clk  input  1  clock; memory writes commit on its rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 (CPU) request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_we  input  1  port 0 store (1) / load (0)
req0_addr  input  DATA_WIDTH  port 0 address
req0_wd  input  DATA_WIDTH  port 0 store data
req0_funct3  input  3  port 0 access size/sign
rsp0_valid  output  1  port 0 response valid (one-cycle pulse)
rsp0_rd  output  DATA_WIDTH  port 0 load data
rsp0_err  output  1  port 0 request was rejected
req1_valid, req1_ready, req1_we, req1_addr, req1_wd, req1_funct3, rsp1_valid, rsp1_rd, rsp1_err  same as port 0, for port 1 (loader)
mem_WE  output  1  memory write enable
mem_A  output  DATA_WIDTH  memory address
mem_WD  output  DATA_WIDTH  memory write data
mem_funct3  output  3  memory funct3
mem_RD  input  DATA_WIDTH  memory combinational read data

Behaviour:
- Reset (async, rst=1): rsp*_valid=0, rsp*_rd=0, rsp*_err=0, priority pointer=0 (port 0 favoured). While rst=1: req*_ready=0 and mem_WE=0.
- Arbitration (combinational, same cycle):
  - Only one port valid: that port is granted.
  - Both ports valid: the port indicated by the priority pointer is granted.
  - The pointer updates at clk to the port not granted, only when a grant occurs.
  - No grant leaves the pointer unchanged.
- reqN_ready=1 only for the granted port; at most one ready per cycle. A transfer is valid&ready.
- Legality check on the granted request:
  - Store: legal iff funct3 is 000, 001 or 010.
  - Load: legal iff funct3 is 000, 001, 010, 100 or 101.
  - Any request with addr > ADDR_MAX is illegal.
- Memory drive (combinational):
  - mem_A, mem_WD and mem_funct3 mux from the granted port; they are port 0 values when there is no grant.
  - mem_WE = granted & we & legal.
  - An illegal request never asserts mem_WE.
- Response timing:
  - A transfer at edge N produces rspX_valid=1 during cycle N+1 only, on the granting port.
  - Legal load: rspX_rd = mem_RD sampled at edge N, rspX_err=0.
  - Legal store: rspX_rd=0, rspX_err=0.
  - Illegal request: rspX_rd=0, rspX_err=1.
  - rsp_rd and rsp_err hold their values when rsp_valid=0.
- Throughput: one transfer per cycle, no bubbles. Back-to-back responses may alternate ports.
- No response backpressure; requesters must accept rsp in the cycle it is presented.
- Requester may change or drop valid before ready without penalty; the arbiter holds no request state.
- Reset mid-operation: a response pending for the next cycle is discarded, and a store granted in the reset cycle is not written.
- A load following a store to the same address in the next cycle returns the new data, since the memory write commits at the edge.

Test Plan:
- Single port 0 store sw addr=0x10 wd=0xDEADBEEF, then lw addr=0x10 → rsp0_valid pulses each cycle; second rsp0_rd=0xDEADBEEF, err=0.
- Both valid continuously for 4 cycles from reset → grant order 0,1,0,1; exactly one ready per cycle; pointer toggles.
- Port 1 lb addr=0x10 after mem[0x10]=0x00000080 → rsp1_rd=0xFFFFFF80. Repeat with lbu → 0x00000080.
- Port 0 store funct3=011 addr=0x20 wd=0x1234 → mem_WE stays 0, rsp0_err=1, rsp0_rd=0, and a later lw 0x20 returns the prior value. Load addr=0x00020000 → err=1.
- Assert rst asynchronously mid-cycle during a granted store to 0x30 → all ready=0, mem_WE=0, no rsp next cycle, mem[0x30] unchanged; after release port 0 wins a simultaneous request.
- Only port 1 valid for 3 cycles, then both valid → port 1 granted 3 times, then port 0 (pointer=0) wins the first contended cycle.
